// File: rtl/uart_packet_parser.sv
// Byte-stream packet parser: SOF, LEN, payload, XOR checksum.
// It holds a good packet until the consumer accepts it, and it pulses errors for bad frames.
module uart_packet_parser #(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SOF          = 8'hA5,
  parameter int         TIMEOUT_CLKS = 17360
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_in,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic [7:0]             pkt_len,
  output logic [8*MAX_LEN-1:0]   pkt_data,
  output logic                   err_cksum,
  output logic                   err_len,
  output logic                   err_timeout,
  output logic                   err_drop
);

  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CKSUM   = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  state_t             state_r;
  logic [7:0]         idx_r;
  logic [7:0]         cksum_r;
  logic [TMO_W-1:0]   tmo_cnt_r;

  logic               sof_s;
  logic               len_ok_s;
  logic               in_frame_s;
  logic               tmo_hit_s;

  assign sof_s      = byte_valid && (byte_in == SOF);
  assign len_ok_s   = (byte_in != 8'd0) && (byte_in <= 8'(MAX_LEN));
  assign in_frame_s = (state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CKSUM);
  // Timeout fires on the idle cycle where the count would reach TIMEOUT_CLKS-1.
  assign tmo_hit_s  = ((TMO_W+1)'(tmo_cnt_r) + (TMO_W+1)'(1)) >= (TMO_W+1)'(TIMEOUT_CLKS - 1);

  // Frame FSM with registered packet outputs and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= 8'd0;
      cksum_r     <= 8'd0;
      tmo_cnt_r   <= '0;
      pkt_valid   <= 1'b0;
      pkt_len     <= 8'd0;
      pkt_data    <= '0;
      err_cksum   <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_drop    <= 1'b0;
    end else begin
      err_cksum   <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_drop    <= 1'b0;

      // Only idle cycles inside a frame advance the counter; a timeout never coincides with a byte.
      if (in_frame_s && !byte_valid) begin
        if (tmo_hit_s) begin
          err_timeout <= 1'b1;
          state_r     <= ST_IDLE;
          tmo_cnt_r   <= '0;
        end else begin
          tmo_cnt_r   <= tmo_cnt_r + TMO_W'(1);
        end
      end else begin
        tmo_cnt_r <= '0;
      end

      case (state_r)
        ST_IDLE: begin
          if (sof_s) begin
            state_r <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (byte_valid) begin
            if (len_ok_s) begin
              pkt_len  <= byte_in;
              cksum_r  <= byte_in;
              idx_r    <= 8'd0;
              pkt_data <= '0;
              state_r  <= ST_PAYLOAD;
            end else begin
              err_len  <= 1'b1;
              state_r  <= ST_IDLE;
            end
          end
        end
        ST_PAYLOAD: begin
          if (byte_valid) begin
            for (int k = 0; k < MAX_LEN; k++) begin
              if (idx_r == 8'(k)) begin
                pkt_data[8*k +: 8] <= byte_in;
              end
            end
            cksum_r <= cksum_r ^ byte_in;
            idx_r   <= idx_r + 8'd1;
            if (idx_r == (pkt_len - 8'd1)) begin
              state_r <= ST_CKSUM;
            end
          end
        end
        ST_CKSUM: begin
          if (byte_valid) begin
            if (byte_in == cksum_r) begin
              pkt_valid <= 1'b1;
              state_r   <= ST_HOLD;
            end else begin
              err_cksum <= 1'b1;
              state_r   <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          // On the handshake cycle, a byte is evaluated as if the parser were already idle.
          if (pkt_ready) begin
            pkt_valid <= 1'b0;
            state_r   <= sof_s ? ST_LEN : ST_IDLE;
          end else if (byte_valid) begin
            err_drop  <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          pkt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_parser.sv
// Directed self-checking bench for uart_packet_parser.
// It uses a short timeout so that the timeout path is exercised quickly.
module tb_uart_packet_parser;

  localparam int TMO = 20;

  logic         clk;
  logic         rst_n;
  logic         byte_valid;
  logic [7:0]   byte_in;
  logic         pkt_valid;
  logic         pkt_ready;
  logic [7:0]   pkt_len;
  logic [127:0] pkt_data;
  logic         err_cksum;
  logic         err_len;
  logic         err_timeout;
  logic         err_drop;

  int checks = 0;
  int errors = 0;

  uart_packet_parser #(.MAX_LEN(16), .SOF(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_in(byte_in),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_len(pkt_len),
    .pkt_data(pkt_data), .err_cksum(err_cksum), .err_len(err_len),
    .err_timeout(err_timeout), .err_drop(err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  function automatic logic [127:0] errs();
    return {124'd0, err_cksum, err_len, err_timeout, err_drop};
  endfunction

  initial begin
    rst_n = 1'b0; byte_valid = 1'b0; byte_in = 8'd0; pkt_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", {127'd0, pkt_valid}, 128'd0);
    chk("rst_data",  pkt_data, 128'd0);
    chk("rst_errs",  errs(), 128'd0);
    rst_n = 1'b1;

    // Basic good frame
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    chk("good_valid", {127'd0, pkt_valid}, 128'd1);
    chk("good_len",   {120'd0, pkt_len}, 128'd3);
    chk("good_data",  pkt_data, 128'h332211);
    @(negedge clk);
    chk("good_release", {127'd0, pkt_valid}, 128'd0);

    // Bad checksum (expected 32), then a good frame
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    chk("cksum_err",   errs(), 128'h8);
    chk("cksum_noval", {127'd0, pkt_valid}, 128'd0);
    @(negedge clk);
    chk("cksum_pulse1", errs(), 128'd0);
    send(8'hA5); send(8'h01); send(8'h44); send(8'h45);
    chk("after_cksum_valid", {127'd0, pkt_valid}, 128'd1);
    chk("after_cksum_data",  pkt_data, 128'h44);

    // Length errors
    send(8'hA5); send(8'h00);
    chk("len0_err", errs(), 128'h4);
    chk("len0_noval", {127'd0, pkt_valid}, 128'd0);
    send(8'hA5); send(8'h11);
    chk("len17_err", errs(), 128'h4);

    // Timeout: the pulse appears TMO-1 cycles after the last byte
    send(8'hA5); send(8'h04); send(8'h01);
    repeat (TMO - 2) @(negedge clk);
    chk("tmo_early", errs(), 128'd0);
    @(negedge clk);
    chk("tmo_fire", errs(), 128'h2);
    @(negedge clk);
    chk("tmo_pulse1", errs(), 128'd0);
    // The next frame carries the SOF value as payload
    send(8'hA5); send(8'h02); send(8'h5A); send(8'hA5); send(8'hFD);
    chk("sof_data_valid", {127'd0, pkt_valid}, 128'd1);
    chk("sof_data_len",   {120'd0, pkt_len}, 128'd2);
    chk("sof_data_data",  pkt_data, 128'hA55A);

    // Hold with backpressure: extra bytes are dropped
    @(negedge clk);
    pkt_ready = 1'b0;
    send(8'hA5); send(8'h01); send(8'h33); send(8'h32);
    chk("hold_valid", {127'd0, pkt_valid}, 128'd1);
    send(8'h12);
    chk("drop1", errs(), 128'h1);
    send(8'h34);
    chk("drop2", errs(), 128'h1);
    chk("drop_data", pkt_data, 128'h33);
    chk("drop_still_valid", {127'd0, pkt_valid}, 128'd1);
    // Handshake together with SOF sends the parser straight to LEN
    @(negedge clk);
    pkt_ready = 1'b1; byte_valid = 1'b1; byte_in = 8'hA5;
    @(negedge clk);
    byte_valid = 1'b0;
    chk("hs_release", {127'd0, pkt_valid}, 128'd0);
    chk("hs_noerr", errs(), 128'd0);
    send(8'h01); send(8'h66); send(8'h67);
    chk("hs_len_valid", {127'd0, pkt_valid}, 128'd1);
    chk("hs_len_data", pkt_data, 128'h66);

    // Reset asserted mid-frame
    send(8'hA5); send(8'h05); send(8'hAA);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {127'd0, pkt_valid}, 128'd0);
    chk("midrst_len",   {120'd0, pkt_len}, 128'd0);
    chk("midrst_data",  pkt_data, 128'd0);
    chk("midrst_errs",  errs(), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    chk("postrst_valid", {127'd0, pkt_valid}, 128'd1);
    chk("postrst_len",   {120'd0, pkt_len}, 128'd1);
    chk("postrst_data",  pkt_data, 128'h7E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_packet_parser.md
UART_PACKET_PARSER -- requirements
Module: uart_packet_parser

Interface
REQ-001 Parameter MAX_LEN, default 16, is the maximum payload bytes per packet (legal range 1..255).
REQ-002 Parameter SOF, default 8'hA5, is the start-of-frame byte value.
REQ-003 Parameter TIMEOUT_CLKS, default 17360, is the maximum number of clk cycles allowed between bytes inside a frame (10 bit times at 1736 clks/bit).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 byte_valid  input  1  one-cycle pulse; byte_in holds a received UART byte.
REQ-007 byte_in  input  8  received byte, sampled only when byte_valid=1.
REQ-008 pkt_valid  output  1  a complete, checksum-good packet is presented.
REQ-009 pkt_ready  input  1  consumer accepts the packet when pkt_valid=1.
REQ-010 pkt_len  output  8  payload byte count of the presented packet.
REQ-011 pkt_data  output  8*MAX_LEN  payload; byte k at bits [8k+7:8k]; unused bytes zero.
REQ-012 err_cksum, err_len, err_timeout, err_drop  output  1 each  one-cycle error pulses.

Function
REQ-013 Frame format SHALL be SOF, LEN, LEN payload bytes, CKSUM, where CKSUM = XOR of LEN and all payload bytes.
REQ-014 States SHALL be IDLE, LEN, PAYLOAD, CKSUM, HOLD.
REQ-015 IDLE: byte_valid with byte_in==SOF -> LEN; any other byte is discarded silently and the state stays IDLE.
REQ-016 LEN: LEN in 1..MAX_LEN -> PAYLOAD, load running XOR with LEN, clear byte index and pkt_data; LEN==0 or LEN>MAX_LEN -> err_len pulse, IDLE.
REQ-017 PAYLOAD: each byte_valid writes byte_in to index idx, XORs it into the running checksum, and increments idx; after byte LEN-1 -> CKSUM.
REQ-018 CKSUM: byte_in==running XOR -> HOLD with pkt_valid=1 on the next cycle; mismatch -> err_cksum pulse, IDLE, pkt_valid stays 0.
REQ-019 Latency SHALL be exactly 1 cycle from the checksum byte_valid to pkt_valid rising.
REQ-020 HOLD: pkt_valid, pkt_len and pkt_data SHALL stay stable until pkt_valid && pkt_ready, then pkt_valid=0 on the next cycle and the state returns to IDLE.
REQ-021 HOLD with byte_valid and without pkt_ready: the byte is dropped and err_drop pulses.
REQ-022 A byte_valid in the same cycle as the HOLD handshake SHALL be processed as in IDLE (an SOF moves directly to LEN).
REQ-023 Timeout counter: cleared on every byte_valid and in IDLE/HOLD; in LEN/PAYLOAD/CKSUM, reaching TIMEOUT_CLKS-1 with no byte_valid -> err_timeout pulse, IDLE.
REQ-024 Each error pulse SHALL be high for exactly one cycle, and at most one error SHALL fire per cycle.
REQ-025 An SOF value inside LEN/PAYLOAD/CKSUM SHALL be treated as data, not as a frame restart.
REQ-026 Counter widths: idx is 8 bits and never exceeds MAX_LEN; the timeout counter is wide enough for TIMEOUT_CLKS with no wrap-around.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, pkt_valid=0, pkt_len=0, pkt_data=0, all err_* =0, and clear idx, checksum and timeout counter, including mid-frame or in HOLD.
REQ-028 After rst_n deasserts, the first byte_valid SHALL be evaluated as in IDLE.

Verification
REQ-029 Bytes A5,03,11,22,33,03 with pkt_ready=1 -> pkt_valid for 1 cycle, pkt_len=3, pkt_data[23:0]=24'h332211, upper bytes 0.
REQ-030 Bytes A5,02,10,20,00 -> err_cksum pulse (expected 32), no pkt_valid, state IDLE; a following good frame is accepted.
REQ-031 Bytes A5,00 and then A5,11 (MAX_LEN=16) -> err_len pulse each time, no pkt_valid.
REQ-032 Bytes A5,04,01 then idle for TIMEOUT_CLKS cycles -> err_timeout at cycle TIMEOUT_CLKS-1 after the last byte; the next frame parses correctly.
REQ-033 Good frame with pkt_ready=0, two extra bytes arrive -> two err_drop pulses, pkt_data unchanged; pkt_ready=1 together with byte A5 -> packet released and the parser is in LEN.
REQ-034 rst_n pulsed low after A5,05,AA -> all outputs 0 during reset; the frame A5,01,7E,7F afterwards yields pkt_len=1, pkt_data[7:0]=7E.
